aes_iter_ctrl: RTL and testbench

Parametrised sequencing controller for the iterative AES-128 engine. It drives the serial key-expansion and data-path slices at LANES bytes per beat. It accepts key/plaintext beats through a valid/ready handshake, runs NR rounds with the final round's MixColumns suppressed, and streams the result out under back-pressure. It sits between the system bus and the key_expansion / aes_data_path instances. It also replaces the fixed-constant, 8-bit, free-running top-level controller.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_iter_ctrl_if.sv | 21 ++
 rtl/aes_lane_dec.sv | 53 +++++
 rtl/aes_iter_ctrl.sv | 136 +++++++++++++
 tb/tb_aes_iter_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the iterative AES sequencing controller
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic [3:0] SUBW_END = 4'd3;
   localparam logic [3:0] NORM_END = 4'd11;

   function automatic bit lanes_ok(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4);
   endfunction

endpackage

// File: rtl/aes_iter_ctrl_if.sv
// rtl/aes_iter_ctrl_if.sv - input/output beat handshake bundle of the AES sequencing controller
interface aes_iter_ctrl_if #(
   parameter int LANES = 1
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [8*LANES-1:0]   out_data;
   logic                 done;

   modport master (
      output in_valid, out_ready,
      input  in_ready, out_valid, out_data, done
   );

   modport slave (
      input  in_valid, out_ready,
      output in_ready, out_valid, out_data, done
   );
endinterface

// File: rtl/aes_lane_dec.sv
// rtl/aes_lane_dec.sv - combinational decode of byte position/round into slice mux controls
module aes_lane_dec
   import aes_pkg::*;
#(
   parameter int LANES = 1,
   parameter int NR    = 10,
   parameter int RW    = 4
) (
   input  state_t           state,
   input  logic [3:0]       byte_idx,
   input  logic [RW-1:0]    round,
   output logic [LANES-1:0] mc_en,
   output logic             pld,
   output logic             input_sel,
   output logic             sbox_sel,
   output logic             last_out_sel,
   output logic             bit_out_sel,
   output logic             rcon_en
);

   localparam logic [RW-1:0] NR_R = RW'(NR);

   logic       run;
   logic       subw;
   logic       norm;
   logic [1:0] lane_lo;

   always_comb begin
      run          = (state == RUN);
      subw         = (byte_idx <= SUBW_END);
      norm         = !subw && (byte_idx <= NORM_END);
      input_sel    = (state == RUN) || (state == OUT);
      sbox_sel     = (state == IDLE) || (state == LOAD) || (run && subw);
      last_out_sel = run && !subw;
      bit_out_sel  = run && (subw || norm);
      rcon_en      = run && (byte_idx == 4'd0);
      mc_en        = '1;
      pld          = 1'b0;
      lane_lo      = 2'd0;
      // Lane j carries byte byte_idx+j; the last byte of each column closes MixColumns.
      for (int j = 0; j < LANES; j++) begin
         lane_lo = byte_idx[1:0] + 2'(j);
         if (run && lane_lo == 2'd3) begin
            mc_en[j] = 1'b0;
            pld      = 1'b1;
         end
         if (run && round == NR_R) begin
            mc_en[j] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/aes_iter_ctrl.sv
// rtl/aes_iter_ctrl.sv - load/run/output sequencing FSM for the iterative AES-128 engine
module aes_iter_ctrl
   import aes_pkg::*;
#(
   parameter int LANES = 1,
   parameter int NR    = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   aes_iter_ctrl_if.slave          bus,
   input  logic                    dbg_sel,
   input  logic [8*LANES-1:0]      dp_data,
   input  logic [8*LANES-1:0]      key_tap,
   output logic                    ce,
   output logic                    input_sel,
   output logic                    sbox_sel,
   output logic                    last_out_sel,
   output logic                    bit_out_sel,
   output logic                    rcon_en,
   output logic                    pld,
   output logic [LANES-1:0]        mc_en,
   output logic [$clog2(NR+1)-1:0] round
);

   localparam int            RW       = $clog2(NR + 1);
   localparam logic [RW-1:0] NR_R     = RW'(NR);
   localparam logic [3:0]    STEP     = 4'(LANES);
   localparam logic [3:0]    LAST_IDX = 4'(16 - LANES);

   if (!lanes_ok(LANES) || NR < 1 || NR > 14) begin : g_bad_param
      $error("aes_iter_ctrl: LANES must be 1, 2 or 4 and NR 1..14");
   end

   state_t             state, state_n;
   logic [3:0]         byte_idx, byte_idx_n;
   logic [RW-1:0]      round_n;
   logic [8*LANES-1:0] res_q;
   logic               done_q, done_n;
   logic               in_rdy, out_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         byte_idx <= 4'd0;
         round    <= '0;
         res_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         byte_idx <= byte_idx_n;
         round    <= round_n;
         done_q   <= done_n;
         if (state == RUN) begin
            res_q <= dp_data;
         end
      end
   end

   always_comb begin
      state_n    = state;
      byte_idx_n = byte_idx;
      round_n    = round;
      done_n     = 1'b0;
      in_rdy     = 1'b0;
      out_vld    = 1'b0;
      ce         = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            ce     = bus.in_valid;
            if (bus.in_valid) begin
               state_n    = LOAD;
               byte_idx_n = STEP;
            end
         end
         LOAD: begin
            in_rdy = 1'b1;
            ce     = bus.in_valid;
            if (bus.in_valid) begin
               byte_idx_n = byte_idx + STEP;
               if (byte_idx == LAST_IDX) begin
                  state_n = RUN;
                  round_n = RW'(1);
               end
            end
         end
         RUN: begin
            ce         = 1'b1;
            byte_idx_n = byte_idx + STEP;
            // Round stays at NR through OUT so the final-round decode never overflows.
            if (byte_idx == LAST_IDX) begin
               if (round == NR_R) begin
                  state_n = OUT;
               end else begin
                  round_n = round + RW'(1);
               end
            end
         end
         OUT: begin
            out_vld = 1'b1;
            if (bus.out_ready) begin
               byte_idx_n = byte_idx + STEP;
               if (byte_idx == LAST_IDX) begin
                  state_n = IDLE;
                  round_n = '0;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.done      = done_q;
   assign bus.out_data  = dbg_sel ? key_tap : res_q;

   aes_lane_dec #(
      .LANES (LANES),
      .NR    (NR),
      .RW    (RW)
   ) u_lane_dec (
      .state        (state),
      .byte_idx     (byte_idx),
      .round        (round),
      .mc_en        (mc_en),
      .pld          (pld),
      .input_sel    (input_sel),
      .sbox_sel     (sbox_sel),
      .last_out_sel (last_out_sel),
      .bit_out_sel  (bit_out_sel),
      .rcon_en      (rcon_en)
   );

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb/tb_aes_iter_ctrl.sv - self-checking bench for aes_iter_ctrl at LANES=1 and LANES=4, NR=10
module tb_aes_iter_ctrl;

   logic clk;
   logic rst1, rst4;

   aes_iter_ctrl_if #(.LANES(1)) if1 ();
   aes_iter_ctrl_if #(.LANES(4)) if4 ();

   logic        dbg_sel1;
   logic [7:0]  dp_data1, key_tap1;
   logic        ce1, input_sel1, sbox_sel1, last_out_sel1, bit_out_sel1, rcon_en1, pld1;
   logic [0:0]  mc_en1;
   logic [3:0]  round1;

   logic        dbg_sel4;
   logic [31:0] dp_data4, key_tap4;
   logic        ce4, input_sel4, sbox_sel4, last_out_sel4, bit_out_sel4, rcon_en4, pld4;
   logic [3:0]  mc_en4;
   logic [3:0]  round4;

   aes_iter_ctrl #(.LANES(1), .NR(10)) u_dut1 (
      .clk(clk), .rst(rst1), .bus(if1), .dbg_sel(dbg_sel1), .dp_data(dp_data1), .key_tap(key_tap1),
      .ce(ce1), .input_sel(input_sel1), .sbox_sel(sbox_sel1), .last_out_sel(last_out_sel1),
      .bit_out_sel(bit_out_sel1), .rcon_en(rcon_en1), .pld(pld1), .mc_en(mc_en1), .round(round1)
   );

   aes_iter_ctrl #(.LANES(4), .NR(10)) u_dut4 (
      .clk(clk), .rst(rst4), .bus(if4), .dbg_sel(dbg_sel4), .dp_data(dp_data4), .key_tap(key_tap4),
      .ce(ce4), .input_sel(input_sel4), .sbox_sel(sbox_sel4), .last_out_sel(last_out_sel4),
      .bit_out_sel(bit_out_sel4), .rcon_en(rcon_en4), .pld(pld4), .mc_en(mc_en4), .round(round4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {sbox_sel, last_out_sel, bit_out_sel, rcon_en, pld, mc_en} for a non-final round
   typedef struct {
      logic [7:0] dp;
      logic [5:0] ctl;
   } run_vec_t;

   run_vec_t    tbl [16];
   logic [31:0] sb_q [$];
   int          n_vec  = 0;
   int          n_miss = 0;

   function automatic run_vec_t mk(input logic [7:0] dp, input logic [5:0] ctl);
      run_vec_t v;
      v.dp  = dp;
      v.ctl = ctl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset1(input string name);
      chk(name, {if1.in_ready, if1.out_valid, if1.done, ce1, pld1, mc_en1, input_sel1, sbox_sel1,
                 last_out_sel1, bit_out_sel1, rcon_en1, round1, if1.out_data},
                {5'b10000, 1'b1, 5'b01000, 4'd0, 8'd0});
   endtask

   task automatic load1(input int pre, input int stall_after, input int stall_len);
      int acc   = pre;
      int stall = 0;
      for (int g = 0; g < 100 && acc < 16; g++) begin
         if (acc == stall_after && stall < stall_len) begin
            if1.in_valid = 1'b0;
            stall++;
         end else begin
            if1.in_valid = 1'b1;
         end
         #2;
         chk("load_ce", ce1, if1.in_valid);
         chk("load_ready", if1.in_ready, 1);
         if (if1.in_valid) acc++;
         tick();
      end
      chk("load_beats", acc, 16);
      if1.in_valid = 1'b0;
   endtask

   task automatic run1(input int abort_at);
      int         lat  = -1;
      int         rcnt = 0;
      int         p, r;
      logic [5:0] ctl;
      logic [7:0] dp;
      for (int i = 0; i < 300; i++) begin
         p = i % 16;
         r = i / 16 + 1;
         dp = tbl[p].dp ^ 8'(r);
         dp_data1     = dp;
         key_tap1     = 8'($urandom);
         if1.in_valid = 1'($urandom_range(0, 1));
         #2;
         if (if1.out_valid) begin
            lat = i;
            break;
         end
         ctl = tbl[p].ctl;
         if (r == 10) ctl[0] = 1'b0;
         chk("run_ctl", {ce1, input_sel1, sbox_sel1, last_out_sel1, bit_out_sel1, rcon_en1, pld1,
                         mc_en1, round1, if1.in_ready},
                        {2'b11, ctl, 4'(r), 1'b0});
         if (rcon_en1) rcnt++;
         if (i == 16 * 10 - 1) repeat (16) sb_q.push_back(32'(dp));
         tick();
         if (i == abort_at) return;
      end
      chk("latency", lat, 160);
      chk("rcon_pulses", rcnt, 10);
   endtask

   task automatic drain1(input bit toggle, input bit dbg_rand, input bit next_valid);
      int          hs      = 0;
      int          last_hs = -5;
      bit          seen    = 1'b0;
      logic [31:0] e;
      for (int i = 0; i < 100 && !seen; i++) begin
         if1.out_ready = toggle ? 1'(i % 2 == 0) : 1'b1;
         dbg_sel1      = dbg_rand ? 1'($urandom_range(0, 1)) : 1'b0;
         key_tap1      = 8'($urandom);
         if1.in_valid  = next_valid;
         #2;
         if (if1.done) begin
            seen = 1'b1;
            chk("done_after_hs", i, last_hs + 1);
            chk("done_in_ready", if1.in_ready, 1);
            chk("sb_empty", sb_q.size(), 0);
         end else begin
            chk("out_valid", if1.out_valid, 1);
            if (dbg_sel1) chk("dbg_tap", if1.out_data, key_tap1);
            if (if1.out_valid && if1.out_ready) begin
               hs++;
               last_hs = i;
               if (sb_q.size() == 0) begin
                  chk("sb_underflow", hs, 16);
               end else begin
                  e = sb_q.pop_front();
                  if (!dbg_sel1) chk("out_beat", if1.out_data, e);
               end
            end
         end
         tick();
      end
      chk("done_seen", seen, 1);
      chk("beat_count", hs, 16);
      dbg_sel1 = 1'b0;
      #2;
      chk("done_once", if1.done, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = mk(8'h3a, 6'b101101);
      tbl[1]  = mk(8'h51, 6'b101001);
      tbl[2]  = mk(8'hc7, 6'b101001);
      tbl[3]  = mk(8'h0e, 6'b101010);
      tbl[4]  = mk(8'h92, 6'b011001);
      tbl[5]  = mk(8'h6b, 6'b011001);
      tbl[6]  = mk(8'hf4, 6'b011001);
      tbl[7]  = mk(8'h28, 6'b011010);
      tbl[8]  = mk(8'hd3, 6'b011001);
      tbl[9]  = mk(8'h17, 6'b011001);
      tbl[10] = mk(8'hae, 6'b011001);
      tbl[11] = mk(8'h45, 6'b011010);
      tbl[12] = mk(8'hb9, 6'b010001);
      tbl[13] = mk(8'h7c, 6'b010001);
      tbl[14] = mk(8'h03, 6'b010001);
      tbl[15] = mk(8'he6, 6'b010010);

      rst1 = 1'b1; rst4 = 1'b1;
      if1.in_valid = 1'b0; if1.out_ready = 1'b0; dbg_sel1 = 1'b0; dp_data1 = '0; key_tap1 = '0;
      if4.in_valid = 1'b0; if4.out_ready = 1'b0; dbg_sel4 = 1'b0; dp_data4 = '0; key_tap4 = '0;
      tick();
      tick();
      rst1 = 1'b0;
      #2;
      check_reset1("reset");

      // back-to-back blocks: the next first beat is offered during the done cycle
      load1(0, 99, 0);
      run1(-1);
      drain1(1'b0, 1'b0, 1'b1);

      load1(1, 7, 5);
      run1(-1);
      drain1(1'b1, 1'b0, 1'b0);

      load1(0, 99, 0);
      run1(16 * 4 + 5);
      if1.in_valid = 1'b0;
      #2;
      chk("pre_rst_round", round1, 5);
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      #2;
      check_reset1("mid_run_reset");
      chk("abort_sb_empty", sb_q.size(), 0);

      load1(0, 3, 2);
      run1(-1);
      drain1(1'b1, 1'b1, 1'b0);

      begin : lanes4
         int          lat  = -1;
         int          hs   = 0;
         bit          seen = 1'b0;
         int          r;
         logic [31:0] e;
         rst4 = 1'b0;
         #2;
         chk("reset4", {if4.in_ready, if4.out_valid, if4.done, ce4, pld4, mc_en4, round4},
                       {5'b10000, 4'hf, 4'd0});
         for (int k = 0; k < 4; k++) begin
            if4.in_valid = 1'b1;
            #2;
            chk("load4_ce", ce4, 1);
            tick();
         end
         if4.in_valid = 1'b0;
         for (int i = 0; i < 100; i++) begin
            dp_data4 = $urandom;
            #2;
            if (if4.out_valid) begin
               lat = i;
               break;
            end
            r = i / 4 + 1;
            chk("run4_ctl", {pld4, mc_en4, ce4, if4.in_ready},
                            {1'b1, (r == 10) ? 4'b0000 : 4'b0111, 1'b1, 1'b0});
            if (i == 39) repeat (4) sb_q.push_back(dp_data4);
            tick();
         end
         chk("latency4", lat, 40);
         for (int i = 0; i < 40 && !seen; i++) begin
            if4.out_ready = 1'b1;
            #2;
            if (if4.done) begin
               seen = 1'b1;
            end else if (if4.out_valid && if4.out_ready) begin
               hs++;
               if (sb_q.size() == 0) begin
                  chk("sb4_underflow", hs, 4);
               end else begin
                  e = sb_q.pop_front();
                  chk("out4_beat", if4.out_data, e);
               end
            end
            tick();
         end
         chk("done4_seen", seen, 1);
         chk("beats4", hs, 4);
         chk("sb4_empty", sb_q.size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
